// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared constants and parameter helpers for updown_modk_counter
package updown_counter_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  function automatic bit params_ok(int n, int k, int p);
    return (n >= 1) && (n <= 30) && (k >= 2) && (k <= (1 << n)) && (p >= 1);
  endfunction

  // Prescaler counter width for a given ratio: clog2(P+1).
  function automatic int pw(int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/updown_modk_counter_prescaler.sv
// rtl/updown_modk_counter_prescaler.sv - counts EN-high cycles modulo P, tick on every P-th
module modk_prescaler
  import updown_counter_pkg::*;
#(
  parameter int P = 1
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic clr,
  input  logic EN,
  output logic tick
);

  localparam int PW = pw(P);
  localparam logic [PW-1:0] LAST = PW'(P - 1);

  logic [PW-1:0] cnt;

  // tick is combinational so the P-th enabled cycle steps the counter on that same edge
  assign tick = (cnt == LAST);

  always_ff @(posedge Clock) begin
    if (!Reset_n || clr) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_modk_counter.sv
// rtl/updown_modk_counter.sv - N-bit mod-K up/down counter; UDCOUNTER_PRESCALE_EN adds an EN prescaler
module updown_modk_counter
  import updown_counter_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 10,
  parameter int P = 1
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         EN,
  input  logic         Up,
  input  logic         Load,
  input  logic [N-1:0] D,
  input  logic         Mode,
  output logic [N-1:0] Q,
  output logic         Cout,
  output logic         Done
);

  generate
    if (!params_ok(N, K, P)) begin : g_bad_params
      $error("updown_modk_counter: illegal N/K/P");
    end
  endgenerate

  localparam logic [N-1:0] KM1   = N'(K - 1);
  localparam logic [N:0]   K_EXT = (N + 1)'(K);

  logic       tick;
  logic       step;
  logic       at_term;
  logic [N:0] q_step;

`ifdef UDCOUNTER_PRESCALE_EN
  modk_prescaler #(.P(P)) u_prescaler (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .clr     (Load),
    .EN      (EN),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign step   = EN & tick & ~Done;
  assign q_step = Up ? ({1'b0, Q} + 1'b1) : ({1'b0, Q} - 1'b1);
  // Going down, the borrow out of the extra bit marks Q==0.
  assign at_term = Up ? (Q == KM1) : q_step[N];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Q    <= '0;
      Cout <= 1'b0;
      Done <= 1'b0;
    end else if (Load) begin
      Q    <= ({1'b0, D} < K_EXT) ? D : KM1;
      Cout <= 1'b0;
      Done <= 1'b0;
    end else if (step) begin
      if (at_term) begin
        Cout <= 1'b1;
        if (Mode == MODE_ONESHOT) begin
          Done <= 1'b1;
        end else begin
          Q <= Up ? '0 : KM1;
        end
      end else begin
        Q    <= q_step[N-1:0];
        Cout <= 1'b0;
      end
    end else begin
      Cout <= 1'b0;
    end
  end

endmodule

// File: doc/updown_modk_counter.md
# updown_modk_counter

Parametrised N-bit modulo-K up/down counter with synchronous parallel load, wrap or one-shot mode, and a registered carry/borrow pulse for cascading. It is the general-purpose counting primitive for the lab designs: it drives digit counters, timers and rate dividers, and its `Cout` feeds the `EN` of the next stage.

## Interface
- `N`, 4: counter width in bits.
- `K`, 10: modulus. Legal range is 2 ≤ K ≤ 2^N; any other value is an elaboration error.
- `P`, 1: prescale ratio, 1 ≤ P. Used only when `UDCOUNTER_PRESCALE_EN` is defined.

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset_n`  in  1  reset, synchronous and active-low.
- `EN`  in  1  count enable.
- `Up`  in  1  direction: 1 = increment, 0 = decrement.
- `Load`  in  1  synchronous parallel load.
- `D`  in  N  load value.
- `Mode`  in  1  0 = wrap, 1 = one-shot.
- `Q`  out  N  count value, registered.
- `Cout`  out  1  registered one-cycle carry/borrow pulse.
- `Done`  out  1  one-shot terminal flag, registered.

## Operation
- **Priority per edge:** `Reset_n` low > `Load` > step > hold.
- **Reset:** `Q`=0, `Cout`=0, `Done`=0. The prescaler is also cleared.
- **Load:**
  - `Q`←`D` if `D`<K; otherwise `Q`←K-1 (clamp).
  - `Cout`←0 and `Done`←0.
  - A step requested in the same cycle is discarded.
- **Step:** a step occurs when `EN`=1 (and `tick`=1 when the prescaler is compiled in) and `Done`=0.
- **Terminal value:** K-1 when `Up`=1; 0 when `Up`=0.
- **Wrap mode (`Mode`=0):**
  - Step up: `Q`←K-1 ? 0 : `Q`+1.
  - Step down: `Q`←0 ? K-1 : `Q`-1.
  - `Cout`←1 only on the wrapping step; otherwise `Cout`←0.
- **One-shot mode (`Mode`=1):**
  - Stepping from a non-terminal value behaves as in wrap mode.
  - A step while at the terminal value: `Q` holds, `Cout`←1 for one cycle, `Done`←1.
  - While `Done`=1, steps are ignored and `Cout` stays 0. Only `Load` or reset clears `Done`.
- **Any cycle without a step:** `Q` holds and `Cout`←0. `Cout` is never sticky.
- **`Up` and `Mode` changes:** may change on any cycle and take effect on the next step. Switching `Mode` from 1 to 0 while `Done`=1 leaves `Done` set, and the counter stays frozen until `Load`.
- **Arithmetic:** performed at N+1 bits internally; the comparison uses K-1 at N bits. There is no overflow path even when K = 2^N.

## Timing
- Latency from `EN` sampled high to the new `Q`: 1 cycle.
- `Cout` is high in exactly the cycle in which `Q` shows the post-wrap value (0 going up, K-1 going down). In one-shot mode it is high in the first cycle `Done`=1.
- Cascading: stage i+1 `EN` = stage i `Cout`. The next stage steps on the edge following the wrap, so it lags by one cycle; this is accepted.
- Reset deasserted mid-count: counting restarts from 0 on the first edge with `Reset_n`=1 and `EN`=1.
- `Load` and reset act on the sampling edge with no bubble. `Q` shows `D` in the next cycle.

## Configuration
- Macro: `UDCOUNTER_PRESCALE_EN`.
- **Defined:** sub-module `modk_prescaler` counts `EN`-high cycles modulo P and asserts `tick` on every P-th one. Step = `EN` & `tick`. The prescaler is cleared by reset and `Load`. With P=1, `tick` is always 1.
- **Undefined:** step = `EN`, P is ignored, and no prescaler logic is instantiated.

## Structure
- Package `updown_counter_pkg` holds:
  - `MODE_WRAP`=1'b0 and `MODE_ONESHOT`=1'b1;
  - the legality-check function for N, K and P;
  - the prescaler width constant `PW`=clog2(P+1).
- Sub-module `modk_prescaler` (parameter P; ports `Clock`, `Reset_n`, `clr`, `EN`, `tick`) is instantiated only under the macro.

## Test plan
- N=4, K=10, wrap mode, `Up`=1, `EN`=1 for 12 cycles after reset → `Q`: 1..9, 0, 1, 2. `Cout`=1 only in the cycle `Q`=0.
- `Up`=0 starting from `Q`=0 → `Q`: 9, 8, 7, with `Cout`=1 in the `Q`=9 cycle. Toggle `EN` low for 2 cycles → `Q` holds and `Cout`=0.
- `Load`=1 with `D`=7 and `EN`=1 in the same cycle → `Q`=7 with no step. `D`=13 → `Q`=9 (clamp).
- One-shot mode, `Up`=1, from 8 → `Q`: 9, 9 (`Cout`=1, `Done`=1), then 9 indefinitely with `Cout`=0. Next `Load` `D`=0 → `Done`=0.
- Two instances cascaded (K=10 each) for 25 steps → high digit 2, low digit 5. Assert `Reset_n`=0 mid-run → both read 0 on the next edge.
- Macro defined, P=3, `EN`=1 constantly → `Q` increments every 3rd cycle. `Load` mid-period restarts the 3-cycle spacing from the load.
